// File: rtl/adder_result_display_if.sv
// Handshake and display bus between the adder result source and adder_result_display.
//   result   : unsigned adder result {carry_out, sum}, WIDTH bits
//   valid    : result is valid this cycle
//   ready    : converter idle and able to capture
//   done     : one-cycle pulse, new digits/segments valid
//   bcd_tens : registered tens digit (0..6)
//   bcd_ones : registered ones digit (0..9)
//   seg_tens : tens segments, bit0=a .. bit6=g
//   seg_ones : ones segments, same bit order
interface adder_result_display_if #(
    parameter int unsigned WIDTH = 5
);
    logic [WIDTH-1:0] result;
    logic             valid;
    logic             ready;
    logic             done;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic [6:0]       seg_tens;
    logic [6:0]       seg_ones;

    modport master (
        output result, valid,
        input  ready, done, bcd_tens, bcd_ones, seg_tens, seg_ones
    );

    modport slave (
        input  result, valid,
        output ready, done, bcd_tens, bcd_ones, seg_tens, seg_ones
    );
endinterface

// File: rtl/adder_result_display.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a
// registered two-digit seven-segment driver.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus_io  : slave side of adder_result_display_if (result/valid in;
//             ready/done/bcd/seg out)
module adder_result_display #(
    parameter int unsigned WIDTH          = 5,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEAD     = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    adder_result_display_if.slave  bus_io
);

    localparam logic [6:0] SegBlank = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SegZero  = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
    localparam logic [6:0] SegTensRst = BLANK_LEAD ? SegBlank : SegZero;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [7:0]       scratch_q, scratch_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [6:0]       seg_tens_q, seg_tens_d;
    logic [6:0]       seg_ones_q, seg_ones_d;
    logic             done_q, done_d;

    logic [7:0]       adj;
    logic [WIDTH+7:0] shifted;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    // Add-3 adjust precedes the shift so each nibble stays a valid BCD digit.
    always_comb begin
        adj[3:0] = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
        adj[7:4] = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
        shifted  = {adj, bin_q} << 1;
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        seg_tens_d = seg_tens_q;
        seg_ones_d = seg_ones_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_io.valid) begin
                    bin_d     = bus_io.result;
                    scratch_d = '0;
                    cnt_d     = 3'(WIDTH);
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = shifted[WIDTH+7:WIDTH];
                bin_d     = shifted[WIDTH-1:0];
                cnt_d     = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                tens_d     = scratch_q[7:4];
                ones_d     = scratch_q[3:0];
                seg_tens_d = (BLANK_LEAD && scratch_q[7:4] == 4'd0) ?
                             SegBlank : seg_encode(scratch_q[7:4]);
                seg_ones_d = seg_encode(scratch_q[3:0]);
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            seg_tens_q <= SegTensRst;
            seg_ones_q <= SegZero;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            seg_tens_q <= seg_tens_d;
            seg_ones_q <= seg_ones_d;
            done_q     <= done_d;
        end
    end

    assign bus_io.ready    = (state_q == StIdle);
    assign bus_io.done     = done_q;
    assign bus_io.bcd_tens = tens_q;
    assign bus_io.bcd_ones = ones_q;
    assign bus_io.seg_tens = seg_tens_q;
    assign bus_io.seg_ones = seg_ones_q;

endmodule

// File: tb/tb_adder_result_display.sv
module tb_adder_result_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_result_display_if #(.WIDTH(5)) bus0 ();
    adder_result_display_if #(.WIDTH(5)) bus1 ();

    adder_result_display #(.WIDTH(5), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEAD(1'b1)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_io  (bus0)
    );

    adder_result_display #(.WIDTH(5), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEAD(1'b0)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_io  (bus1)
    );

    int checks = 0;
    int fails  = 0;
    int n_push = 0;
    int n_done = 0;
    // Expected entry: {tens[3:0], ones[3:0], seg_tens[6:0], seg_ones[6:0]}
    logic [21:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [21:0] exp_of(input int v);
        logic [6:0] tab [10];
        logic [3:0] t;
        logic [3:0] o;
        logic [6:0] st;
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        t  = 4'(v / 10);
        o  = 4'(v % 10);
        st = (t == 4'd0) ? 7'h7F : ~tab[t];
        return {t, o, st, ~tab[o]};
    endfunction

    // Monitor: every o_done pops one expectation.
    always @(negedge clk) begin
        if (bus0.done === 1'b1) begin
            logic [21:0] e;
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pending result at %0t",
                         $time);
            end else begin
                e = exp_q.pop_front();
                check("bcd_tens", 32'(bus0.bcd_tens), 32'(e[21:18]));
                check("bcd_ones", 32'(bus0.bcd_ones), 32'(e[17:14]));
                check("seg_tens", 32'(bus0.seg_tens), 32'(e[13:7]));
                check("seg_ones", 32'(bus0.seg_ones), 32'(e[6:0]));
                check("ready_with_done", 32'(bus0.ready), 32'd1);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus0.ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(bus0.ready), 32'd1);
    endtask

    // Capture v, then count edges until ready returns.
    task automatic convert(input logic [4:0] v, input logic [21:0] e);
        int n = 0;
        wait_ready();
        bus0.result = v;
        bus0.valid  = 1'b1;
        exp_q.push_back(e);
        n_push++;
        @(posedge clk); #1;
        bus0.valid = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus0.ready !== 1'b1 && n < 20);
        check("busy_edges", 32'(n), 32'd6);
        check("done_pulse", 32'(bus0.done), 32'd1);
    endtask

    initial begin
        int n;
        bus0.valid = 1'b0;
        bus0.result = '0;
        bus1.valid = 1'b0;
        bus1.result = '0;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready", 32'(bus0.ready), 32'd1);
        check("rst_done", 32'(bus0.done), 32'd0);
        check("rst_tens", 32'(bus0.bcd_tens), 32'd0);
        check("rst_ones", 32'(bus0.bcd_ones), 32'd0);
        check("rst_seg_ones", 32'(bus0.seg_ones), 32'h40);
        check("rst_seg_tens", 32'(bus0.seg_tens), 32'h7F);
        check("rst_seg_tens_noblank", 32'(bus1.seg_tens), 32'h40);

        // Directed vectors
        convert(5'd31, {4'd3, 4'd1, 7'h30, 7'h79});
        convert(5'd0,  {4'd0, 4'd0, 7'h7F, 7'h40});
        convert(5'd10, {4'd1, 4'd0, 7'h79, 7'h40});

        // Leading zero not blanked on the BLANK_LEAD=0 instance
        bus1.result = 5'd0;
        bus1.valid  = 1'b1;
        @(posedge clk); #1;
        bus1.valid = 1'b0;
        n = 0;
        while (bus1.done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("nb_latency", 32'(n), 32'd6);
        check("nb_seg_tens", 32'(bus1.seg_tens), 32'h40);
        check("nb_seg_ones", 32'(bus1.seg_ones), 32'h40);
        check("nb_tens", 32'(bus1.bcd_tens), 32'd0);

        // Capture 19, then offer 9 while busy; only 19 must come out
        wait_ready();
        bus0.result = 5'd19;
        bus0.valid  = 1'b1;
        exp_q.push_back({4'd1, 4'd9, 7'h79, 7'h10});
        n_push++;
        @(posedge clk); #1;
        bus0.result = 5'd9;
        repeat (3) @(posedge clk);
        #1 bus0.valid = 1'b0;
        wait_ready();
        repeat (10) @(posedge clk);
        #1 check("busy_ignored_queue", 32'(exp_q.size()), 32'd0);

        // Abort 27 with reset sampled on the 3rd shift edge
        wait_ready();
        bus0.result = 5'd27;
        bus0.valid  = 1'b1;
        @(posedge clk); #1;
        bus0.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", 32'(bus0.ready), 32'd1);
        check("abort_done", 32'(bus0.done), 32'd0);
        check("abort_tens", 32'(bus0.bcd_tens), 32'd0);
        check("abort_ones", 32'(bus0.bcd_ones), 32'd0);
        check("abort_seg_ones", 32'(bus0.seg_ones), 32'h40);
        check("abort_seg_tens", 32'(bus0.seg_tens), 32'h7F);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        convert(5'd27, {4'd2, 4'd7, 7'h24, 7'h78});

        // Sweep at maximum throughput
        for (int v = 0; v < 32; v++) begin
            convert(5'(v), exp_of(v));
        end

        repeat (10) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
